bin2bcd_seq: RTL and testbench

- Sequential binary-to-BCD converter (iterative double-dabble, shift-add-3).
- Takes the 16-bit product of the radix-4 8-bit multiplier and produces packed BCD digits plus a sign flag.
- Sits directly upstream of the 7-segment digit decoders: each 4-bit field of bcd drives one decoder.
- Start/busy/done handshake; the result stays stable between conversions so the display never glitches.

---
 rtl/bin2bcd_pkg.sv | 24 ++
 rtl/bcd_add3.sv | 16 +
 rtl/bin2bcd_seq.sv | 105 ++++++++++
 tb/tb_bin2bcd_seq.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Contents: FSM state enum, default operand/digit sizes, and the iteration
// counter width derived from the operand width.
package bin2bcd_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    localparam int DEF_WIDTH  = 16;
    localparam int DEF_DIGITS = 5;

    // The counter must hold the value WIDTH itself, hence WIDTH+1.
    function automatic int cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

    localparam int CNT_W = cnt_w(DEF_WIDTH);

endpackage

// File: rtl/bcd_add3.sv
// Single-digit double-dabble corrector: adds 3 to a digit of 5 or more.
// Latency: combinational, zero cycles.
// Backpressure: none (pure function of its input).
//
// Ports:
//   digit : BCD digit before the shift step
//   fixed : corrected digit, so that the following left shift carries into
//           the next decade instead of producing a code 10..15
module bcd_add3 (
    input  logic [3:0] digit,
    output logic [3:0] fixed
);

    assign fixed = (digit >= 4'd5) ? (digit + 4'd3) : digit;

endmodule

// File: rtl/bin2bcd_seq.sv
// Iterative binary-to-BCD converter (shift-add-3), sign + magnitude output.
// Latency: WIDTH+1 cycles from the accepting start edge to the done cycle.
// Backpressure: start is only sampled while idle; requests during busy are dropped.
//
// Ports:
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   start      : conversion request, accepted only in IDLE (bin captured then)
//   bin        : binary operand, two's complement when SIGNED_IN=1
//   busy       : conversion in progress
//   done       : one-cycle pulse, bcd/neg updated on the edge that raises it
//   bcd        : packed BCD, [3:0] = units digit
//   neg        : operand was negative (always 0 when SIGNED_IN=0)
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int DIGITS    = DEF_DIGITS,
    parameter bit SIGNED_IN = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  neg
);

    localparam int BW = 4 * DIGITS;
    localparam int SW = BW + WIDTH;
    localparam int CW = cnt_w(WIDTH);

    state_t          state;
    logic [SW-1:0]   scratch;   // {BCD accumulator, remaining binary bits}
    logic [CW-1:0]   cnt;
    logic            sign_p;    // sign of the operand being converted

    logic [BW-1:0]   acc_fix;
    logic [SW-1:0]   shifted;
    logic [WIDTH-1:0] mag;
    logic            mag_neg;

    // Per-digit add-3 correction on the accumulator half of the scratch.
    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .digit (scratch[WIDTH + 4*g +: 4]),
            .fixed (acc_fix[4*g +: 4])
        );
    end

    // The shift drops the MSB of the top digit; with 10^DIGITS > 2^WIDTH
    // that bit is always zero.
    always_comb begin
        shifted = {acc_fix, scratch[WIDTH-1:0]} << 1;
    end

    // Negation is taken modulo 2^WIDTH, so the most negative operand maps
    // to its correct unsigned magnitude (e.g. 0x8000 -> 32768).
    always_comb begin
        mag_neg = SIGNED_IN && bin[WIDTH-1];
        mag     = mag_neg ? (~bin + WIDTH'(1)) : bin;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            scratch <= '0;
            cnt     <= '0;
            sign_p  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            bcd     <= '0;
            neg     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        scratch <= {{BW{1'b0}}, mag};
                        cnt     <= CW'(WIDTH);
                        sign_p  <= mag_neg;
                        busy    <= 1'b1;
                        state   <= CONV;
                    end
                end
                CONV: begin
                    scratch <= shifted;
                    cnt     <= cnt - CW'(1);
                    // Last iteration: publish directly from the shift result
                    // so done lands exactly WIDTH edges after acceptance.
                    if (cnt == CW'(1)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        bcd   <= shifted[SW-1:WIDTH];
                        neg   <= sign_p;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: one unsigned and one signed instance.
// Latency: n/a.
// Backpressure: n/a.
module tb_bin2bcd_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        u_start = 1'b0, s_start = 1'b0;
    logic [15:0] u_bin = '0, s_bin = '0;
    logic        u_busy, u_done, u_neg, s_busy, s_done, s_neg;
    logic [19:0] u_bcd, s_bcd;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    bin2bcd_seq #(.WIDTH(16), .DIGITS(5), .SIGNED_IN(1'b0)) u_dut_u (
        .clk   (clk),
        .rst_n (rst_n),
        .start (u_start),
        .bin   (u_bin),
        .busy  (u_busy),
        .done  (u_done),
        .bcd   (u_bcd),
        .neg   (u_neg)
    );

    bin2bcd_seq #(.WIDTH(16), .DIGITS(5), .SIGNED_IN(1'b1)) u_dut_s (
        .clk   (clk),
        .rst_n (rst_n),
        .start (s_start),
        .bin   (s_bin),
        .busy  (s_busy),
        .done  (s_done),
        .bcd   (s_bcd),
        .neg   (s_neg)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: integer value of the operand, then decimal digits by /10.
    function automatic logic [19:0] ref_bcd(input logic [15:0] b, input bit sgn, output bit n);
        int v;
        logic [19:0] r;
        if (sgn && b[15]) begin
            v = 65536 - int'(b);
            n = 1'b1;
        end else begin
            v = int'(b);
            n = 1'b0;
        end
        r = '0;
        for (int i = 0; i < 5; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic bit digits_ok(input logic [19:0] d);
        for (int i = 0; i < 5; i++)
            if (d[4*i +: 4] > 4'd9) return 1'b0;
        return 1'b1;
    endfunction

    // One conversion on the selected instance. lat counts clock edges from the
    // accepting edge (inclusive) to the edge that raised done.
    task automatic convert(input bit s, input logic [15:0] b,
                           output int lat, output int bcnt,
                           output logic [19:0] rb, output logic rn, output int held_bad);
        logic [19:0] prev;
        @(negedge clk);
        if (s) begin s_start = 1'b1; s_bin = b; end
        else   begin u_start = 1'b1; u_bin = b; end
        prev = s ? s_bcd : u_bcd;
        lat = 0; bcnt = 0; held_bad = 0;
        @(posedge clk);
        #1;
        u_start = 1'b0;
        s_start = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (s ? s_busy : u_busy) bcnt++;
            if (s ? s_done : u_done) begin
                lat = k;
                break;
            end
            if ((s ? s_bcd : u_bcd) !== prev) held_bad++;
        end
        if (lat == 0) chk("timeout_done", 32'd0, 32'd1);
        rb = s ? s_bcd : u_bcd;
        rn = s ? s_neg : u_neg;
    endtask

    task automatic run_and_check(input string tag, input bit s, input logic [15:0] b);
        int lat, bcnt, hb;
        logic [19:0] rb, eb;
        logic rn;
        bit en;
        eb = ref_bcd(b, s, en);
        convert(s, b, lat, bcnt, rb, rn, hb);
        chk({tag, "_bcd"}, 32'(rb), 32'(eb));
        chk({tag, "_neg"}, 32'(rn), 32'(en));
        chk({tag, "_lat"}, lat, 17);
        chk({tag, "_busy"}, bcnt, 16);
        chk({tag, "_held"}, hb, 0);
        chk({tag, "_dig"}, 32'(digits_ok(rb)), 32'd1);
    endtask

    initial begin
        int lat, bcnt, hb, ndone, bad, first;
        int times[$];
        logic [19:0] rb, prev;
        logic rn;

        // Reset state
        #12;
        chk("rst_u_busy", 32'(u_busy), 0);
        chk("rst_u_done", 32'(u_done), 0);
        chk("rst_u_bcd",  32'(u_bcd), 0);
        chk("rst_s_neg",  32'(s_neg), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Directed values
        run_and_check("u3039", 1'b0, 16'h3039);
        chk("u3039_abs", 32'(u_bcd), 32'h12345);
        @(negedge clk);
        chk("done_pulse", 32'(u_done), 0);
        run_and_check("uFFFF", 1'b0, 16'hFFFF);
        chk("uFFFF_abs", 32'(u_bcd), 32'h65535);
        run_and_check("u0000", 1'b0, 16'h0000);
        run_and_check("sFFF6", 1'b1, 16'hFFF6);
        chk("sFFF6_abs", 32'({s_neg, s_bcd}), 32'h1_00010);
        run_and_check("s8000", 1'b1, 16'h8000);
        chk("s8000_abs", 32'({s_neg, s_bcd}), 32'h1_32768);
        run_and_check("s7FFF", 1'b1, 16'h7FFF);
        chk("s7FFF_abs", 32'({s_neg, s_bcd}), 32'h0_32767);
        run_and_check("s0000", 1'b1, 16'h0000);

        // Start pulsed mid-conversion is ignored
        @(negedge clk);
        u_start = 1'b1; u_bin = 16'h04D2;
        prev = u_bcd;
        @(posedge clk); #1 u_start = 1'b0;
        repeat (5) @(negedge clk);
        u_start = 1'b1; u_bin = 16'h0064;
        @(negedge clk);
        u_start = 1'b0;
        ndone = 0; bad = 0; rb = '0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (u_done) begin
                if (ndone == 0) rb = u_bcd;
                ndone++;
            end else if (ndone == 0 && u_bcd !== prev) bad++;
        end
        chk("mid_ndone", ndone, 1);
        chk("mid_bcd", 32'(rb), 32'h01234);
        chk("mid_held", bad, 0);

        // Held start: back-to-back conversions
        @(negedge clk);
        u_bin = 16'h0001; u_start = 1'b1;
        bad = 0;
        for (int k = 1; k <= 70; k++) begin
            @(negedge clk);
            if (u_done) begin
                times.push_back(k);
                if (u_bcd !== 20'h00001) bad++;
            end
        end
        u_start = 1'b0;
        chk("held_ndone", times.size(), 4);
        if (times.size() >= 3) begin
            chk("held_first", times[0], 17);
            chk("held_int1", times[1] - times[0], 17);
            chk("held_int2", times[2] - times[1], 17);
        end
        chk("held_bcd", bad, 0);
        repeat (20) @(negedge clk);

        // Reset during a conversion
        @(negedge clk);
        u_start = 1'b1; u_bin = 16'h1234;
        @(posedge clk); #1 u_start = 1'b0;
        repeat (8) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(u_busy), 0);
        chk("arst_done", 32'(u_done), 0);
        chk("arst_bcd",  32'(u_bcd), 0);
        chk("arst_neg",  32'(s_neg), 0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        repeat (20) begin
            @(negedge clk);
            if (u_done) ndone++;
        end
        chk("arst_nodone", ndone, 0);
        run_and_check("u1234", 1'b0, 16'h1234);
        chk("u1234_abs", 32'(u_bcd), 32'h04660);

        // Randomized against the model
        for (int i = 0; i < 30; i++) begin
            run_and_check("rnd_u", 1'b0, 16'($urandom_range(0, 65535)));
            run_and_check("rnd_s", 1'b1, 16'($urandom_range(0, 65535)));
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
